// File: rtl/arrow_pkg.sv
// Shared definitions for the arrow motion controller.
//   arrow_state_t : controller state encoding (IDLE / FLYING / COOLDOWN)
//   *_DEF         : default geometry and timing values for arrow_move_ctrl
//   COORD_W       : width of all pixel coordinates
package arrow_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } arrow_state_t;

  localparam int unsigned COORD_W             = 11;
  localparam int unsigned ARROW_SPEED_DEF     = 4;
  localparam int unsigned Y_FLOOR_DEF         = 440;
  localparam int unsigned CHAR_X_OFFSET_DEF   = 16;
  localparam int unsigned COOLDOWN_FRAMES_DEF = 8;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a key level input.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   in     : key level (high while held)
//   rise   : high for the clk in which 'in' is high and was low on the previous clk
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/arrow_move_ctrl.sv
// Arrow motion controller, downstream of the border/collision detector.
// Launches an arrow from the character on a fire key press, grows it upward
// once per frame, retracts it on a ceiling or bubble hit, then holds off new
// shots for a cooldown period.
//   clk            : system clock
//   resetN         : asynchronous active-low reset
//   startOfFrame   : 1-clk pulse at frame start
//   pause          : freeze motion and counters (hit flags still accumulate)
//   fireKey        : fire key level
//   charX          : character left X
//   arrowHitTop    : arrow drawn on row 0 this clk
//   arrowHitBubble : arrow/bubble overlap this clk
//   arrowActive    : arrow exists
//   arrowX         : arrow column, latched at launch
//   arrowTopY      : arrow tip row (base fixed at Y_FLOOR)
//   arrowFired     : 1-clk pulse on launch
//   arrowPopped    : 1-clk pulse when a bubble hit retracts the arrow
module arrow_move_ctrl
  import arrow_pkg::*;
#(
  parameter int unsigned ARROW_SPEED     = ARROW_SPEED_DEF,
  parameter int unsigned Y_FLOOR         = Y_FLOOR_DEF,
  parameter int unsigned CHAR_X_OFFSET   = CHAR_X_OFFSET_DEF,
  parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               pause,
  input  logic               fireKey,
  input  logic [COORD_W-1:0] charX,
  input  logic               arrowHitTop,
  input  logic               arrowHitBubble,
  output logic               arrowActive,
  output logic [COORD_W-1:0] arrowX,
  output logic [COORD_W-1:0] arrowTopY,
  output logic               arrowFired,
  output logic               arrowPopped
);

  localparam int unsigned CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  localparam logic [COORD_W-1:0] Y_FLOOR_C  = COORD_W'(Y_FLOOR);
  localparam logic [COORD_W-1:0] SPEED_C    = COORD_W'(ARROW_SPEED);
  localparam logic [COORD_W-1:0] X_OFFSET_C = COORD_W'(CHAR_X_OFFSET);
  localparam logic [CNT_W-1:0]   CNT_LAST_C = CNT_W'(COOLDOWN_FRAMES - 1);

  arrow_state_t       state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] top_q, top_d;
  logic               active_q, active_d;
  logic               fired_q, fired_d;
  logic               popped_q, popped_d;
  logic               hit_top_q, hit_top_d;
  logic               hit_bub_q, hit_bub_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic press;
  logic flying;
  logic frame_tick;
  logic hit_top_now;
  logic hit_bub_now;

  key_edge_detect u_fire_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (fireKey),
    .rise   (press)
  );

  assign flying     = (state_q == FLYING);
  assign frame_tick = startOfFrame & ~pause;

  // A strobe landing on the startOfFrame clk itself still counts for the
  // frame being evaluated, since the flags are cleared on that same edge.
  assign hit_top_now = hit_top_q | (flying & arrowHitTop);
  assign hit_bub_now = hit_bub_q | (flying & arrowHitBubble);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    top_d     = top_q;
    active_d  = active_q;
    fired_d   = 1'b0;
    popped_d  = 1'b0;
    cnt_d     = cnt_q;
    hit_top_d = hit_top_now;
    hit_bub_d = hit_bub_now;

    unique case (state_q)
      IDLE: begin
        if (press && !pause) begin
          state_d  = FLYING;
          x_d      = charX + X_OFFSET_C;
          top_d    = Y_FLOOR_C;
          active_d = 1'b1;
          fired_d  = 1'b1;
        end
      end

      FLYING: begin
        if (frame_tick) begin
          if (hit_bub_now || hit_top_now || (top_q == '0)) begin
            state_d  = COOLDOWN;
            active_d = 1'b0;
            top_d    = Y_FLOOR_C;
            cnt_d    = '0;
            popped_d = hit_bub_now;
          end else begin
            top_d = (top_q > SPEED_C) ? (top_q - SPEED_C) : '0;
          end
        end
      end

      COOLDOWN: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST_C) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_tick) begin
      hit_top_d = 1'b0;
      hit_bub_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      x_q       <= '0;
      top_q     <= Y_FLOOR_C;
      active_q  <= 1'b0;
      fired_q   <= 1'b0;
      popped_q  <= 1'b0;
      hit_top_q <= 1'b0;
      hit_bub_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      top_q     <= top_d;
      active_q  <= active_d;
      fired_q   <= fired_d;
      popped_q  <= popped_d;
      hit_top_q <= hit_top_d;
      hit_bub_q <= hit_bub_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arrowActive = active_q;
  assign arrowX      = x_q;
  assign arrowTopY   = top_q;
  assign arrowFired  = fired_q;
  assign arrowPopped = popped_q;

endmodule

// File: tb/tb_arrow_move_ctrl.sv
// Scoreboard bench for arrow_move_ctrl. Stimulus pushes the expected output
// record for each fire / pop / retract event or explicit snapshot; a monitor
// on the falling clock edge pops and compares whenever one of those occurs.
module tb_arrow_move_ctrl;

  localparam int K_SNAP = 0;
  localparam int K_FIRE = 1;
  localparam int K_POP  = 2;
  localparam int K_RETR = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        pause = 1'b0;
  logic        fireKey = 1'b0;
  logic [10:0] charX = '0;
  logic        arrowHitTop = 1'b0;
  logic        arrowHitBubble = 1'b0;
  logic        arrowActive;
  logic [10:0] arrowX;
  logic [10:0] arrowTopY;
  logic        arrowFired;
  logic        arrowPopped;

  logic snap_r = 1'b0;
  logic act_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          kind;
    logic        act;
    logic [10:0] x;
    logic [10:0] y;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  arrow_move_ctrl #(
    .ARROW_SPEED     (4),
    .Y_FLOOR         (440),
    .CHAR_X_OFFSET   (16),
    .COOLDOWN_FRAMES (8)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pause          (pause),
    .fireKey        (fireKey),
    .charX          (charX),
    .arrowHitTop    (arrowHitTop),
    .arrowHitBubble (arrowHitBubble),
    .arrowActive    (arrowActive),
    .arrowX         (arrowX),
    .arrowTopY      (arrowTopY),
    .arrowFired     (arrowFired),
    .arrowPopped    (arrowPopped)
  );

  function automatic string kname(input int k);
    case (k)
      K_SNAP:  return "snap";
      K_FIRE:  return "fire";
      K_POP:   return "pop";
      default: return "retract";
    endcase
  endfunction

  task automatic push(input int k, input logic a, input int x, input int y);
    exp_t e;
    e.kind = k;
    e.act  = a;
    e.x    = 11'(x);
    e.y    = 11'(y);
    sb.push_back(e);
  endtask

  task automatic compare(input int k);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s at %0t: got act=%0b x=%0d y=%0d, required no event",
               kname(k), $time, arrowActive, arrowX, arrowTopY);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || arrowActive !== e.act || arrowX !== e.x || arrowTopY !== e.y) begin
        errors++;
        $display("FAIL check%0d_%s at %0t: got %s act=%0b x=%0d y=%0d, required %s act=%0b x=%0d y=%0d",
                 checks, kname(e.kind), $time, kname(k), arrowActive, arrowX, arrowTopY,
                 kname(e.kind), e.act, e.x, e.y);
      end
    end
  endtask

  // Monitor: DUT events first, then any snapshot requested in this cycle.
  always @(negedge clk) begin
    if (arrowFired || arrowPopped || (act_prev && !arrowActive)) begin
      if (arrowFired)       compare(K_FIRE);
      else if (arrowPopped) compare(K_POP);
      else                  compare(K_RETR);
    end
    if (snap_r) compare(K_SNAP);
    act_prev = arrowActive;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    snap_r = 1'b1;
    tick();
    snap_r = 1'b0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic frame_press();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    fireKey = 1'b1;
    tick();
    fireKey = 1'b0;
    tick();
  endtask

  task automatic press();
    fireKey = 1'b1;
    tick();
    fireKey = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic t, input logic b);
    arrowHitTop    = t;
    arrowHitBubble = b;
    tick();
    arrowHitTop    = 1'b0;
    arrowHitBubble = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus, required completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    tick();
    tick();
    push(K_SNAP, 0, 0, 440);
    snap();
    resetN = 1'b1;
    tick();

    // Launch from charX=100, hold key for 50 frames; charX moves after launch
    charX = 11'd100;
    push(K_FIRE, 1, 116, 440);
    fireKey = 1'b1;
    tick();
    charX = 11'd300;
    frames(50);
    push(K_SNAP, 1, 116, 240);
    snap();

    // Release, tip reaches 0 after 110 frames total
    fireKey = 1'b0;
    frames(60);
    push(K_SNAP, 1, 116, 0);
    snap();

    // Retract at next frame; presses blocked for 8 frames, accepted on the 9th
    push(K_RETR, 0, 116, 440);
    frame_press();
    for (int i = 0; i < 7; i++) frame_press();
    push(K_FIRE, 1, 316, 440);
    frame_press();

    // Bubble hit with tip at 300
    frames(35);
    push(K_SNAP, 1, 316, 300);
    snap();
    strobe(1'b0, 1'b1);
    push(K_POP, 0, 316, 440);
    frame();
    frames(8);

    // Strobes in IDLE are ignored; launch with 11-bit X wrap (2040+16 -> 8)
    charX = 11'd2040;
    strobe(1'b1, 1'b1);
    push(K_FIRE, 1, 8, 440);
    press();
    frame();
    push(K_SNAP, 1, 8, 436);
    snap();

    // Top and bubble in the same frame: bubble wins
    strobe(1'b1, 1'b1);
    push(K_POP, 0, 8, 440);
    frame();
    frames(8);

    // Top-only hit: retract without pop
    charX = 11'd0;
    push(K_FIRE, 1, 16, 440);
    press();
    frame();
    strobe(1'b1, 1'b0);
    push(K_RETR, 0, 16, 440);
    frame();
    frames(8);

    // Pause freezes the tip and drops presses; flags still accumulate
    charX = 11'd50;
    push(K_FIRE, 1, 66, 440);
    press();
    frames(3);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) frame_press();
    strobe(1'b0, 1'b1);
    push(K_SNAP, 1, 66, 428);
    snap();
    pause = 1'b0;
    push(K_POP, 0, 66, 440);
    frame();
    frames(8);

    // Press during pause in IDLE is dropped
    pause = 1'b1;
    press();
    pause = 1'b0;
    frame();
    push(K_SNAP, 0, 66, 440);
    snap();

    // startOfFrame on the press clk: launch only, first rise on the next frame
    charX = 11'd10;
    push(K_FIRE, 1, 26, 440);
    startOfFrame = 1'b1;
    fireKey = 1'b1;
    tick();
    startOfFrame = 1'b0;
    fireKey = 1'b0;
    tick();
    push(K_SNAP, 1, 26, 440);
    snap();
    frame();
    push(K_SNAP, 1, 26, 436);
    snap();
    frame();

    // Asynchronous reset mid-flight: outputs drop before the next clock edge
    push(K_RETR, 0, 0, 440);
    push(K_SNAP, 0, 0, 440);
    resetN = 1'b0;
    snap_r = 1'b1;
    tick();
    snap_r = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
    tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending records, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
